serial_subtractor: RTL and testbench

//   Bit-serial SIZE-bit subtractor: d = a - b - bin, with borrow-out bout.

---
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin (mod 2^SIZE), borrow-out in bout.
// One bit per clock, LSB first, under a start/done handshake.
module serial_subtractor #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] d,
  output logic            bout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

  state_t          state;
  logic [SIZE-1:0] ra;
  logic [SIZE-1:0] rb;
  logic [SIZE-1:0] sr;
  logic            brw;
  logic [CNT_W-1:0] cnt;

  logic            x;
  logic            diff_bit;
  logic            brw_next;
  logic [SIZE-1:0] sr_next;

  // Full-subtractor bit slice on the current LSBs plus the shift-register update
  always_comb begin
    x        = ra[0] ^ rb[0];
    diff_bit = x ^ brw;
    brw_next = (~ra[0] & rb[0]) | (~x & brw);
    sr_next  = {diff_bit, sr[SIZE-1:1]};
  end

  // Control FSM, operand shifting and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      sr    <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            ra    <= a;
            rb    <= b;
            brw   <= bin;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          ra  <= {1'b0, ra[SIZE-1:1]};
          rb  <= {1'b0, rb[SIZE-1:1]};
          brw <= brw_next;
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            d     <= sr_next;
            bout  <= brw_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// operands checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned SIZE  = 4;
  localparam int unsigned CNT_W = 3;
  localparam int MAX_WAIT = 30;

  logic            clk;
  logic            rst;
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            bin;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] d;
  logic            bout;

  int total;
  int bad;

  // Expected visible result (last completed operation, zero after reset)
  logic [SIZE-1:0] held_d;
  logic            held_bout;

  serial_subtractor #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic
  function automatic logic [SIZE-1:0] ref_d(input int ia, input int ib, input int ibin);
    int r;
    r = ia - ib - ibin;
    r = r & ((1 << SIZE) - 1);
    return SIZE'(r);
  endfunction

  function automatic logic ref_bout(input int ia, input int ib, input int ibin);
    return (ia < ib + ibin);
  endfunction

  // Called at a negedge; start is seen at the next posedge (E0)
  task automatic start_op(input logic [SIZE-1:0] ta, input logic [SIZE-1:0] tb, input logic tbin);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = SIZE'($urandom); b = SIZE'($urandom); bin = 1'($urandom);
  endtask

  // Counts negedges until done is seen; d/bout must stay at the held values meanwhile
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < MAX_WAIT) begin
      chk({tag, "_hold_d"}, 32'(d), 32'(held_d));
      chk({tag, "_hold_bout"}, 32'(bout), 32'(held_bout));
      @(negedge clk);
      n++;
    end
    if (n >= MAX_WAIT) chk({tag, "_timeout"}, 32'(done), 32'(1));
  endtask

  // Full operation from a negedge; returns at the negedge where done is high
  task automatic run_op(input string tag, input logic [SIZE-1:0] ta,
                        input logic [SIZE-1:0] tb, input logic tbin);
    int n;
    logic [SIZE-1:0] ed;
    logic            eb;
    ed = ref_d(int'(ta), int'(tb), int'(tbin));
    eb = ref_bout(int'(ta), int'(tb), int'(tbin));
    start_op(ta, tb, tbin);
    chk({tag, "_busy"}, 32'(busy), 32'(1));
    wait_done(tag, n);
    chk({tag, "_latency"}, 32'(n), 32'(SIZE));
    chk({tag, "_d"}, 32'(d), 32'(ed));
    chk({tag, "_bout"}, 32'(bout), 32'(eb));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    held_d = ed;
    held_bout = eb;
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_no_done"}, 32'(done), 32'(0));
      chk({tag, "_not_busy"}, 32'(busy), 32'(0));
    end
  endtask

  initial begin
    int n;
    logic [SIZE-1:0] ra_t, rb_t;
    logic            rbin_t;
    total = 0; bad = 0;
    held_d = '0; held_bout = 1'b0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_d", 32'(d), 32'(0));
    chk("reset_bout", 32'(bout), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op("c_minus_3", 4'b1100, 4'b0011, 1'b0);
    quiet_cycles("c_minus_3_after", 1);
    run_op("3_minus_c", 4'b0011, 4'b1100, 1'b0);
    quiet_cycles("3_minus_c_after", 1);
    run_op("zero_bin", 4'b0000, 4'b0000, 1'b1);
    quiet_cycles("zero_bin_after", 1);

    // Back-to-back: new start accepted in the DONE cycle
    run_op("f_minus_f", 4'b1111, 4'b1111, 1'b0);
    run_op("b2b_7_minus_1", 4'b0111, 4'b0001, 1'b0);
    quiet_cycles("b2b_after", 2);

    // Start pulsed mid-SHIFT is ignored
    start_op(4'b1010, 4'b0110, 1'b1);
    @(negedge clk);
    a = 4'b0001; b = 4'b1110; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", n);
    chk("ignore_start_latency", 32'(n), 32'(SIZE - 2));
    chk("ignore_start_d", 32'(d), 32'(ref_d(10, 6, 1)));
    chk("ignore_start_bout", 32'(bout), 32'(ref_bout(10, 6, 1)));
    held_d = ref_d(10, 6, 1);
    held_bout = ref_bout(10, 6, 1);
    quiet_cycles("ignore_start_single_done", 8);

    // Reset two cycles into SHIFT abandons the operation
    start_op(4'b0101, 4'b1001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_d", 32'(d), 32'(0));
    chk("midrst_bout", 32'(bout), 32'(0));
    held_d = '0; held_bout = 1'b0;
    quiet_cycles("midrst_no_done", 8);
    run_op("after_rst", 4'b0110, 4'b0010, 1'b1);
    quiet_cycles("after_rst_idle", 1);

    // Random operands; occasionally chained back-to-back
    for (int k = 0; k < 40; k++) begin
      ra_t = SIZE'($urandom);
      rb_t = SIZE'($urandom);
      rbin_t = 1'($urandom);
      run_op($sformatf("rand%0d", k), ra_t, rb_t, rbin_t);
      if ($urandom_range(0, 1) == 0) quiet_cycles($sformatf("rand%0d_idle", k), 1);
    end
    quiet_cycles("final", 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
